// File: rtl/arb_pkg.sv
// arb_pkg: shared state, owner and latched-request types for the memory arbiter
package arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_CNT_W  = 4;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  we;
    } arb_req_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of consecutive conflicts lost by fetch
module starve_counter
    import arb_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

    assign at_limit_o = cnt_q == ARB_CNT_W'(LIMIT);

    // clear has priority; increment stops once the limit is reached
    always_comb cnt_d = clr_i ? '0 : (inc_i && !at_limit_o) ? cnt_q + 1'b1 : cnt_q;

    // count register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data requesters
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    arb_req_t             req_q, req_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]    if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic                 idle, done, if_win, at_limit;

    assign idle   = state_q == ARB_IDLE;
    assign done   = !idle && cnt_q == ARB_CNT_W'(1);
    assign if_win = if_req && (!d_req || at_limit);
    assign if_gnt = idle && if_win;
    assign d_gnt  = idle && d_req && !if_win;
    assign busy   = !idle;

    assign mem_en    = busy;
    assign mem_rw    = busy && req_q.we;
    assign mem_addr  = busy ? ADDR_W'(req_q.addr) : '0;
    assign mem_wdata = busy ? DATA_W'(req_q.wdata) : '0;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (d_gnt && if_req),
        .clr_i     (if_gnt),
        .at_limit_o(at_limit)
    );

    // grant and latch in IDLE; count down the hold and return the response in WAIT
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (idle) begin
            if (if_gnt || d_gnt) begin
                state_d     = ARB_WAIT;
                owner_d     = if_gnt ? OWN_IF : OWN_D;
                req_d.addr  = ARB_ADDR_W'(if_gnt ? if_addr : d_addr);
                req_d.wdata = if_gnt ? '0 : ARB_DATA_W'(d_wdata);
                req_d.we    = d_gnt && d_we;
                cnt_d       = ARB_CNT_W'(MEM_LATENCY);
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (done) begin
                state_d     = ARB_IDLE;
                if_rvalid_d = owner_q == OWN_IF;
                d_rvalid_d  = owner_q == OWN_D;
                if_rdata_d  = owner_q == OWN_IF ? mem_rdata : if_rdata_q;
                d_rdata_d   = owner_q == OWN_D ? (req_q.we ? '0 : mem_rdata) : d_rdata_q;
            end
        end
    end

    // state, latched request and response registers; reset aborts any access
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            req_q       <= '0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
endmodule
